mu0_mem_arbiter: RTL and testbench

- Shares the single synchronous 16-bit MU0 RAM between two requesters: the UART host command path (memory read/write override) and the MU0 CPU core.
- Grants at most one access per cycle and registers the command toward the RAM.
- Routes read data back to whichever requester issued the read, tagged with a valid strobe.
- Host lock: while the host holds lock, the CPU is locked out of memory and stalled.

---
 rtl/mu0_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mu0_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_mem_arbiter.sv
// Two-port arbiter sharing the MU0 synchronous RAM between the UART host
// path and the CPU core; round-robin on ties, host lock stalls the CPU.
module mu0_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_lock,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_grant,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_grant,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } owner_e;

  localparam logic [ADDR_W-1:0] LP_WORDS = ADDR_W'(MEM_WORDS);

  owner_e            r_last_owner;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_tag_vld;
  logic              r_tag_host;
  logic              r_tag_oor;
  logic              r_dat_oor;
  logic              r_host_rvalid;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_host_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic              w_host_grant;
  logic              w_cpu_grant;
  logic              w_any;
  logic              w_sel_rnw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_word;

  always_comb begin
    w_host_grant = 1'b0;
    w_cpu_grant  = 1'b0;
    if (rst_n) begin
      if (host_lock) begin
        w_host_grant = host_req;
      end else if (host_req && cpu_req) begin
        w_host_grant = (r_last_owner == OWN_CPU);
        w_cpu_grant  = (r_last_owner == OWN_HOST);
      end else begin
        w_host_grant = host_req;
        w_cpu_grant  = cpu_req;
      end
    end
  end

  assign w_any       = w_host_grant | w_cpu_grant;
  assign w_sel_rnw   = w_host_grant ? host_rnw   : cpu_rnw;
  assign w_sel_addr  = w_host_grant ? host_addr  : cpu_addr;
  assign w_sel_wdata = w_host_grant ? host_wdata : cpu_wdata;
  assign w_in_range  = (w_sel_addr < LP_WORDS);

  // Out-of-range reads still travel the tag pipe and return zero.
  assign w_rd_word = r_dat_oor ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner  <= OWN_CPU;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_tag_vld     <= 1'b0;
      r_tag_host    <= 1'b0;
      r_tag_oor     <= 1'b0;
      r_dat_oor     <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rdata  <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      if (w_any) begin
        r_last_owner <= w_host_grant ? OWN_HOST : OWN_CPU;
      end
      r_mem_en <= w_any & w_in_range;
      r_mem_we <= w_any & w_in_range & ~w_sel_rnw;
      if (w_any && w_in_range) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      r_tag_vld     <= w_any & w_sel_rnw;
      r_tag_host    <= w_host_grant;
      r_tag_oor     <= ~w_in_range;
      r_host_rvalid <= r_tag_vld & r_tag_host;
      r_cpu_rvalid  <= r_tag_vld & ~r_tag_host;
      r_dat_oor     <= r_tag_oor;
      if (r_host_rvalid) begin
        r_host_rdata <= w_rd_word;
      end
      if (r_cpu_rvalid) begin
        r_cpu_rdata <= w_rd_word;
      end
    end
  end

  assign host_grant  = w_host_grant;
  assign cpu_grant   = w_cpu_grant;
  assign cpu_stall   = cpu_req & ~w_cpu_grant;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign host_rvalid = r_host_rvalid;
  assign cpu_rvalid  = r_cpu_rvalid;
  // RAM output is live in the rvalid cycle, then held in the rdata register.
  assign host_rdata  = r_host_rvalid ? w_rd_word : r_host_rdata;
  assign cpu_rdata   = r_cpu_rvalid  ? w_rd_word : r_cpu_rdata;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Scoreboard bench for mu0_mem_arbiter with a behavioural 32-word RAM.
// Issue side queues expected reads; the monitor pops on each rvalid.
module tb_mu0_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_lock, host_req, host_rnw;
  logic [15:0] host_addr, host_wdata;
  logic        host_grant, host_rvalid;
  logic [15:0] host_rdata;
  logic        cpu_req, cpu_rnw;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_grant, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t hq[$];
  exp_t cq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] ram [0:31];

  mu0_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_lock(host_lock), .host_req(host_req), .host_rnw(host_rnw),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_grant(host_grant), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_grant(cpu_grant),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word i initially holds 0xA000 + i.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ram[i] <= 16'hA000 + 16'(i);
      mem_rdata <= 16'h0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[4:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag,
                              input logic eh, input logic ec,
                              input logic ph, input logic [15:0] dh,
                              input logic pc, input logic [15:0] dc);
    @(negedge clk);
    chk({tag, "_host_grant"}, 32'(host_grant), 32'(eh));
    chk({tag, "_cpu_grant"}, 32'(cpu_grant), 32'(ec));
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(cpu_req & ~ec));
    if (ph) hq.push_back('{d: dh, c: cyc});
    if (pc) cq.push_back('{d: dc, c: cyc});
  endtask

  always @(negedge clk) begin
    if (host_rvalid) begin
      if (hq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL host_rvalid_unexpected: got 1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = hq.pop_front();
        chk("host_rdata", 32'(host_rdata), 32'(e.d));
        chk("host_rvalid_cycle", 32'(cyc), 32'(e.c + 2));
      end
    end
    if (cpu_rvalid) begin
      if (cq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cpu_rvalid_unexpected: got 1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = cq.pop_front();
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e.d));
        chk("cpu_rvalid_cycle", 32'(cyc), 32'(e.c + 2));
      end
    end
  end

  initial begin
    int h;
    int c;
    rst_n = 1'b0;
    host_lock = 1'b0;
    host_req = 1'b1; host_rnw = 1'b1; host_addr = 16'd1; host_wdata = 16'h0;
    cpu_req = 1'b1;  cpu_rnw = 1'b1;  cpu_addr = 16'd2;  cpu_wdata = 16'h0;

    // Reset with stray requests
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_host_grant", 32'(host_grant), 32'h0);
    chk("rst_cpu_grant", 32'(cpu_grant), 32'h0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    nxt();
    rst_n = 1'b1;
    expect_grant("s1a", 1'b1, 1'b0, 1'b1, 16'hA001, 1'b0, 16'h0);
    nxt();
    host_req = 1'b0;
    expect_grant("s1b", 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA002);
    nxt();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("s1_mem_en", 32'(mem_en), 32'h1);
    chk("s1_mem_we", 32'(mem_we), 32'h0);
    chk("s1_mem_addr", 32'(mem_addr), 32'h2);

    // Host locked write then read of word 3, CPU stalled
    nxt();
    host_lock = 1'b1;
    host_req = 1'b1; host_rnw = 1'b0; host_addr = 16'd3; host_wdata = 16'h1234;
    cpu_req = 1'b1;  cpu_rnw = 1'b1;  cpu_addr = 16'd7;
    expect_grant("s2w", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    nxt();
    host_rnw = 1'b1;
    expect_grant("s2r", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0);
    chk("s2_mem_en", 32'(mem_en), 32'h1);
    chk("s2_mem_we", 32'(mem_we), 32'h1);
    chk("s2_mem_addr", 32'(mem_addr), 32'h3);
    chk("s2_mem_wdata", 32'(mem_wdata), 32'h1234);
    nxt();
    host_req = 1'b0;
    expect_grant("s2i0", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("s2_rd_mem_we", 32'(mem_we), 32'h0);
    chk("s2_rd_mem_en", 32'(mem_en), 32'h1);
    repeat (2) begin
      nxt();
      expect_grant("s2i", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    end
    nxt();
    host_lock = 1'b0;
    expect_grant("s2c", 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA007);
    nxt();
    cpu_req = 1'b0;

    // Both requesting: round robin, last owner is CPU
    host_req = 1'b1; cpu_req = 1'b1;
    h = 0; c = 0;
    for (int k = 0; k < 6; k++) begin
      host_addr = 16'(8 + h);
      cpu_addr  = 16'(16 + c);
      if (k % 2 == 0) begin
        expect_grant("s3h", 1'b1, 1'b0, 1'b1, 16'hA000 + 16'(8 + h),
                     1'b0, 16'h0);
        h++;
      end else begin
        expect_grant("s3c", 1'b0, 1'b1, 1'b0, 16'h0,
                     1'b1, 16'hA000 + 16'(16 + c));
        c++;
      end
      nxt();
    end

    // Host read @5 granted, lock rises while CPU read @6 waits
    host_addr = 16'd5;
    cpu_addr  = 16'd6;
    expect_grant("s4h", 1'b1, 1'b0, 1'b1, 16'hA005, 1'b0, 16'h0);
    nxt();
    host_req = 1'b0;
    host_lock = 1'b1;
    expect_grant("s4l0", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) begin
      nxt();
      expect_grant("s4l", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    end
    nxt();
    host_lock = 1'b0;
    expect_grant("s4c", 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hA006);
    nxt();
    cpu_req = 1'b0;

    // Out-of-range CPU read @40
    cpu_req = 1'b1;
    cpu_addr = 16'd40;
    expect_grant("s5", 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0000);
    nxt();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("s5_mem_en", 32'(mem_en), 32'h0);
    chk("s5_mem_addr_hold", 32'(mem_addr), 32'h6);
    repeat (3) nxt();
    @(negedge clk);
    chk("s5_host_rdata_hold", 32'(host_rdata), 32'hA005);

    // Reset one cycle after a host read grant cancels the read
    nxt();
    host_req = 1'b1;
    host_addr = 16'd9;
    expect_grant("s6", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    nxt();
    host_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_mem_en", 32'(mem_en), 32'h0);
    chk("s6_mem_addr", 32'(mem_addr), 32'h0);
    chk("s6_host_rvalid", 32'(host_rvalid), 32'h0);
    chk("s6_host_rdata", 32'(host_rdata), 32'h0);
    chk("s6_cpu_rdata", 32'(cpu_rdata), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) nxt();
    @(negedge clk);
    chk("end_host_queue_empty", 32'(hq.size()), 32'h0);
    chk("end_cpu_queue_empty", 32'(cq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
